// File: rtl/fsm_fitness_eval.sv
// Fitness evaluator: steps a chromosome-encoded Mealy FSM over a stimulus
// and scores its outputs against the expected sequence.
module fsm_fitness_eval #(
    parameter int SEQ_LEN     = 5,
    parameter int NUM_STATES  = 3,
    parameter int CHROM_W     = 24,
    parameter int FIT_W       = 4,
    parameter int WEIGHT_ONE  = 3,
    parameter int WEIGHT_ZERO = 1,
    parameter int TAG_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHROM_W-1:0] in_chrom,
    input  logic [SEQ_LEN-1:0] in_seq,
    input  logic [SEQ_LEN-1:0] in_expected,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIT_W-1:0]   out_fitness,
    output logic [SEQ_LEN-1:0] out_outseq,
    output logic               out_match,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CHROM_W-1:0] out_chrom
);

    localparam int ST_W   = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int GI_W   = ST_W + 1;
    localparam int SEL_W  = GI_W + 2;

    localparam logic [FIT_W:0]    FIT_MAX = {1'b0, {FIT_W{1'b1}}};
    localparam logic [FIT_W:0]    W_ONE   = (FIT_W+1)'(WEIGHT_ONE);
    localparam logic [FIT_W:0]    W_ZERO  = (FIT_W+1)'(WEIGHT_ZERO);
    localparam logic [STEP_W-1:0] LAST    = STEP_W'(SEQ_LEN - 1);
    localparam logic [3:0]        NS_MOD  = 4'(NUM_STATES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_t;

    ctrl_t state_q, state_d;

    logic [CHROM_W-1:0] chrom_q;
    logic [SEQ_LEN-1:0] seq_q;
    logic [SEQ_LEN-1:0] exp_q;
    logic [TAG_W-1:0]   tag_q;
    logic [ST_W-1:0]    fsm_q;
    logic [STEP_W-1:0]  step_q;
    logic [FIT_W-1:0]   fit_q;
    logic [SEQ_LEN-1:0] outseq_q;

    logic [STEP_W-1:0] bit_idx;
    logic              cur_bit;
    logic              exp_bit;
    logic              out_bit;
    logic [GI_W-1:0]   gene_idx;
    logic [SEL_W-1:0]  gene_sel;
    logic [3:0]        gene;
    logic [ST_W-1:0]   fsm_nxt;
    logic [FIT_W:0]    fit_sum;
    logic [FIT_W-1:0]  fit_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)       state_d = RUN;
            RUN:     if (step_q == LAST) state_d = DONE;
            DONE:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Step k reads bit SEQ_LEN-1-k; {state, bit} is exactly state*2+bit.
    always_comb begin
        bit_idx  = LAST - step_q;
        cur_bit  = seq_q[bit_idx];
        exp_bit  = exp_q[bit_idx];
        gene_idx = {fsm_q, cur_bit};
        gene_sel = {gene_idx, 2'b00};
        gene     = chrom_q[gene_sel +: 4];
        out_bit  = gene[3];
        fsm_nxt  = ST_W'({1'b0, gene[2:0]} % NS_MOD);
        fit_sum  = {1'b0, fit_q} + (exp_bit ? W_ONE : W_ZERO);
        fit_nxt  = (fit_sum > FIT_MAX) ? FIT_MAX[FIT_W-1:0]
                                       : fit_sum[FIT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chrom_q  <= '0;
            seq_q    <= '0;
            exp_q    <= '0;
            tag_q    <= '0;
            fsm_q    <= '0;
            step_q   <= '0;
            fit_q    <= '0;
            outseq_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        chrom_q  <= in_chrom;
                        seq_q    <= in_seq;
                        exp_q    <= in_expected;
                        tag_q    <= in_tag;
                        fsm_q    <= '0;
                        step_q   <= '0;
                        fit_q    <= '0;
                        outseq_q <= '0;
                    end
                end
                RUN: begin
                    outseq_q[bit_idx] <= out_bit;
                    if (out_bit == exp_bit) fit_q <= fit_nxt;
                    fsm_q  <= fsm_nxt;
                    step_q <= step_q + STEP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_fitness = fit_q;
    assign out_outseq  = outseq_q;
    assign out_match   = out_valid && (outseq_q == exp_q);
    assign out_tag     = tag_q;
    assign out_chrom   = chrom_q;

endmodule

// File: tb/tb_fsm_fitness_eval.sv
// Randomized bench for fsm_fitness_eval against a step-by-step
// reference of the chromosome-encoded Mealy machine.
module tb_fsm_fitness_eval;

    localparam int SEQ_LEN = 5;
    localparam int NS      = 3;
    localparam int CW      = 24;
    localparam int FW      = 4;
    localparam int TW      = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_chrom = '0;
    logic [4:0]    in_seq = '0;
    logic [4:0]    in_expected = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_fitness;
    logic [4:0]    out_outseq;
    logic          out_match;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] out_chrom;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fsm_fitness_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_chrom   (in_chrom),
        .in_seq     (in_seq),
        .in_expected(in_expected),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fitness(out_fitness),
        .out_outseq (out_outseq),
        .out_match  (out_match),
        .out_tag    (out_tag),
        .out_chrom  (out_chrom)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [CW-1:0] c,
                                  input logic [4:0] s,
                                  input logic [4:0] e,
                                  output logic [4:0] o,
                                  output int f);
        int st, b, g, gene, ob, eb;
        o  = '0;
        f  = 0;
        st = 0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            b    = int'(s[SEQ_LEN-1-k]);
            eb   = int'(e[SEQ_LEN-1-k]);
            g    = st * 2 + b;
            gene = int'((c >> (4 * g)) & 24'hF);
            ob   = gene / 8;
            o[SEQ_LEN-1-k] = (ob == 1);
            if (ob == eb) f += (eb == 1) ? 3 : 1;
            st = (gene % 8) % NS;
        end
        if (f > 15) f = 15;
    endfunction

    task automatic start_req(input logic [CW-1:0] c, input logic [4:0] s,
                             input logic [4:0] e, input logic [TW-1:0] t,
                             input bit keep);
        in_valid    = 1'b1;
        in_chrom    = c;
        in_seq      = s;
        in_expected = e;
        in_tag      = t;
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
        in_chrom    = CW'($urandom);
        in_seq      = 5'($urandom);
        in_expected = 5'($urandom);
        in_tag      = TW'($urandom);
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("ready_low_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd5);
    endtask

    task automatic check_result(input logic [CW-1:0] c, input logic [4:0] s,
                                input logic [4:0] e, input logic [TW-1:0] t);
        logic [4:0] o;
        int f;
        model(c, s, e, o, f);
        chk("outseq", 32'(out_outseq), 32'(o));
        chk("fitness", 32'(out_fitness), 32'(f));
        chk("match", 32'(out_match), 32'(o == e));
        chk("tag", 32'(out_tag), 32'(t));
        chk("chrom", 32'(out_chrom), 32'(c));
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_after_pop", 32'(out_valid), 32'd0);
        chk("ready_after_pop", 32'(in_ready), 32'd1);
    endtask

    task automatic eval(input logic [CW-1:0] c, input logic [4:0] s,
                        input logic [4:0] e, input logic [TW-1:0] t);
        start_req(c, s, e, t, 1'b0);
        wait_done();
        check_result(c, s, e, t);
        pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] rc;
        logic [4:0]    rs, re;
        logic [TW-1:0] rt;
        logic [FW-1:0] held_fit;
        logic [4:0]    held_seq;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fit", 32'(out_fitness), 32'd0);
        chk("rst_outseq", 32'(out_outseq), 32'd0);
        chk("rst_match", 32'(out_match), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_chrom", 32'(out_chrom), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived constants.
        start_req(24'h901210, 5'b00101, 5'b00001, 5'd3, 1'b0);
        wait_done();
        chk("hand_outseq", 32'(out_outseq), 32'b00001);
        chk("hand_fit", 32'(out_fitness), 32'd7);
        chk("hand_match", 32'(out_match), 32'd1);
        chk("hand_tag", 32'(out_tag), 32'd3);
        pop();

        start_req(24'h000000, 5'b00101, 5'b00001, 5'd4, 1'b0);
        wait_done();
        chk("zero_outseq", 32'(out_outseq), 32'b00000);
        chk("zero_fit", 32'(out_fitness), 32'd4);
        chk("zero_match", 32'(out_match), 32'd0);
        pop();

        start_req(24'hFFFFFF, 5'b00101, 5'b00001, 5'd5, 1'b0);
        wait_done();
        chk("ones_outseq", 32'(out_outseq), 32'b11111);
        chk("ones_fit", 32'(out_fitness), 32'd3);
        pop();

        start_req(24'h901210, 5'b11111, 5'b11111, 5'd6, 1'b0);
        wait_done();
        chk("floor_outseq", 32'(out_outseq), 32'b00000);
        chk("floor_fit", 32'(out_fitness), 32'd0);
        chk("floor_match", 32'(out_match), 32'd0);
        pop();

        for (int i = 0; i < 25; i++) begin
            rc = CW'($urandom);
            rs = 5'($urandom);
            re = 5'($urandom);
            rt = TW'($urandom);
            eval(rc, rs, re, rt);
        end

        // Backpressure with a second request held on in_valid.
        start_req(24'h901210, 5'b00101, 5'b00001, 5'd9, 1'b1);
        rc = CW'($urandom);
        rs = 5'($urandom);
        re = 5'($urandom);
        rt = TW'($urandom);
        in_chrom    = rc;
        in_seq      = rs;
        in_expected = re;
        in_tag      = rt;
        wait_done();
        held_fit = out_fitness;
        held_seq = out_outseq;
        chk("bp_fit", 32'(held_fit), 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_fit_hold", 32'(out_fitness), 32'(held_fit));
            chk("bp_seq_hold", 32'(out_outseq), 32'(held_seq));
            chk("bp_tag_hold", 32'(out_tag), 32'd9);
        end
        pop();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();
        check_result(rc, rs, re, rt);
        pop();

        // Reset in the middle of RUN, then a clean rerun.
        start_req(24'h901210, 5'b00101, 5'b00001, 5'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_fit", 32'(out_fitness), 32'd0);
        chk("mid_rst_outseq", 32'(out_outseq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_result_after_rst", 32'(out_valid), 32'd0);
        end
        start_req(24'h901210, 5'b00101, 5'b00001, 5'd3, 1'b0);
        wait_done();
        chk("rerun_fit", 32'(out_fitness), 32'd7);
        chk("rerun_match", 32'(out_match), 32'd1);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
